wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 53 +++++
 rtl/wb_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_wb_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_pkg / wb_arbiter_if
//
// Purpose : shared register-file sizing constants plus the bus interface that
//           connects NUM_SRC functional-unit result sources and the register
//           file write ports to the write-back arbiter.
//
// Signals :
//   src_valid   [NUM_SRC]                  source i presents a result
//   src_ready   [NUM_SRC]                  source i may transfer this cycle
//   src_index   [NUM_SRC] x IDX_W          destination physical register
//   src_data    [NUM_SRC] x WORD_SIZE      result value
//   write_ports [NUM_WRITE_PORTS]          RegFileWritePort {en, index_in, data_in}
//
// Modports:
//   slave  - the arbiter (consumes source results, drives write ports)
//   master - the environment (functional units and register file)
// -----------------------------------------------------------------------------
package reg_pkg;
    parameter int WORD_SIZE     = 64;
    parameter int NUM_PHYS_REGS = 128;
endpackage

interface wb_arbiter_if #(
    parameter int WORD_SIZE       = reg_pkg::WORD_SIZE,
    parameter int NUM_PHYS_REGS   = reg_pkg::NUM_PHYS_REGS,
    parameter int NUM_SRC         = 4,
    parameter int NUM_WRITE_PORTS = 2
);
    localparam int IDX_W = (NUM_PHYS_REGS > 1) ? $clog2(NUM_PHYS_REGS) : 1;

    typedef struct packed {
        logic                 en;
        logic [IDX_W-1:0]     index_in;
        logic [WORD_SIZE-1:0] data_in;
    } RegFileWritePort;

    logic [NUM_SRC-1:0]                 src_valid;
    logic [NUM_SRC-1:0]                 src_ready;
    logic [NUM_SRC-1:0][IDX_W-1:0]      src_index;
    logic [NUM_SRC-1:0][WORD_SIZE-1:0]  src_data;
    RegFileWritePort [NUM_WRITE_PORTS-1:0] write_ports;

    modport slave (
        input  src_valid, src_index, src_data,
        output src_ready, write_ports
    );

    modport master (
        output src_valid, src_index, src_data,
        input  src_ready, write_ports
    );
endinterface

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Purpose : collects results from NUM_SRC functional units, buffers each in a
//           private 2-entry FIFO and grants up to NUM_WRITE_PORTS heads per
//           cycle onto the register-file write ports, round-robin, never
//           granting two heads with the same destination index in one cycle.
//
// Ports   :
//   clk  - single clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - wb_arbiter_if.slave (src_valid/src_ready/src_index/src_data in,
//          write_ports out, all write-port fields registered)
//
// Config  : WB_ARBITER_BYPASS_EN - when defined, a source with an empty FIFO
//           competes directly with its live input; a granted result skips the
//           FIFO and reaches write_ports one cycle after transfer. Undefined
//           (default): every result is buffered, two-cycle minimum latency.
// -----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int WORD_SIZE       = reg_pkg::WORD_SIZE,
    parameter int NUM_PHYS_REGS   = reg_pkg::NUM_PHYS_REGS,
    parameter int NUM_SRC         = 4,
    parameter int NUM_WRITE_PORTS = 2
) (
    input  logic           clk,
    input  logic           rst,
    wb_arbiter_if.slave    bus
);
    localparam int IDX_W = (NUM_PHYS_REGS > 1) ? $clog2(NUM_PHYS_REGS) : 1;
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Per-source FIFO state
    logic [NUM_SRC-1:0][1:0]                 r_cnt;
    logic [NUM_SRC-1:0]                      r_rd_ptr;
    logic [NUM_SRC-1:0]                      r_wr_ptr;
    logic [NUM_SRC-1:0][1:0][IDX_W-1:0]      r_mem_idx;
    logic [NUM_SRC-1:0][1:0][WORD_SIZE-1:0]  r_mem_data;

    logic [SRC_W-1:0]                        r_rr_ptr;

    // Registered write-port outputs
    logic [NUM_WRITE_PORTS-1:0]                 r_wp_en;
    logic [NUM_WRITE_PORTS-1:0][IDX_W-1:0]      r_wp_idx;
    logic [NUM_WRITE_PORTS-1:0][WORD_SIZE-1:0]  r_wp_data;

    // Arbitration candidates
    logic [NUM_SRC-1:0]                 w_head_vld;
    logic [NUM_SRC-1:0][IDX_W-1:0]      w_head_idx;
    logic [NUM_SRC-1:0][WORD_SIZE-1:0]  w_head_data;

    logic [NUM_SRC-1:0]                 w_grant;
    logic [NUM_SRC-1:0]                 w_push;
    logic [NUM_SRC-1:0]                 w_pop;

    logic [NUM_WRITE_PORTS-1:0]                 w_slot_en;
    logic [NUM_WRITE_PORTS-1:0][IDX_W-1:0]      w_slot_idx;
    logic [NUM_WRITE_PORTS-1:0][WORD_SIZE-1:0]  w_slot_data;
    logic [SRC_W-1:0]                           w_rr_nxt;

    // Scan temporaries
    int                w_scan_pos;
    int                w_n_gnt;
    int                w_nxt_pos;
    logic [SRC_W-1:0]  w_scan;
    logic              w_conflict;

    // Ready depends on registered occupancy only, so no path exists from
    // src_valid or the grant logic back into src_ready.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            bus.src_ready[i] = (r_cnt[i] < 2'd2);
        end
    end

    // Candidate head per source
    always_comb begin
        w_head_vld  = '0;
        w_head_idx  = '0;
        w_head_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef WB_ARBITER_BYPASS_EN
            // Empty FIFO: the live input competes in its place.
            if (r_cnt[i] != 2'd0) begin
                w_head_vld[i]  = 1'b1;
                w_head_idx[i]  = r_mem_idx[i][r_rd_ptr[i]];
                w_head_data[i] = r_mem_data[i][r_rd_ptr[i]];
            end else begin
                w_head_vld[i]  = bus.src_valid[i];
                w_head_idx[i]  = bus.src_index[i];
                w_head_data[i] = bus.src_data[i];
            end
`else
            w_head_vld[i]  = (r_cnt[i] != 2'd0);
            w_head_idx[i]  = r_mem_idx[i][r_rd_ptr[i]];
            w_head_data[i] = r_mem_data[i][r_rd_ptr[i]];
`endif
        end
    end

    // Round-robin scan starting at r_rr_ptr. The k-th grant fills slot k.
    // A head whose index matches a slot already filled this cycle is skipped
    // and keeps its place for the next cycle.
    always_comb begin
        w_grant     = '0;
        w_slot_en   = '0;
        w_slot_idx  = '0;
        w_slot_data = '0;
        w_rr_nxt    = r_rr_ptr;
        w_n_gnt     = 0;
        w_scan_pos  = 0;
        w_nxt_pos   = 0;
        w_scan      = '0;
        w_conflict  = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            w_scan_pos = int'(r_rr_ptr) + j;
            if (w_scan_pos >= NUM_SRC) begin
                w_scan_pos = w_scan_pos - NUM_SRC;
            end
            w_scan     = w_scan_pos[SRC_W-1:0];
            w_conflict = 1'b0;
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                if (k < w_n_gnt && w_slot_idx[k] == w_head_idx[w_scan]) begin
                    w_conflict = 1'b1;
                end
            end
            if (w_head_vld[w_scan] && (w_n_gnt < NUM_WRITE_PORTS) && !w_conflict) begin
                w_grant[w_scan] = 1'b1;
                for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                    if (k == w_n_gnt) begin
                        w_slot_en[k]   = 1'b1;
                        w_slot_idx[k]  = w_head_idx[w_scan];
                        w_slot_data[k] = w_head_data[w_scan];
                    end
                end
                w_n_gnt   = w_n_gnt + 1;
                w_nxt_pos = w_scan_pos + 1;
                if (w_nxt_pos >= NUM_SRC) begin
                    w_nxt_pos = 0;
                end
                w_rr_nxt  = w_nxt_pos[SRC_W-1:0];
            end
        end
    end

    // FIFO push/pop decisions
    always_comb begin
        w_push = '0;
        w_pop  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
`ifdef WB_ARBITER_BYPASS_EN
            // A grant on an empty FIFO was the live input: it never lands.
            w_push[i] = bus.src_valid[i] && bus.src_ready[i]
                        && !(w_grant[i] && (r_cnt[i] == 2'd0));
            w_pop[i]  = w_grant[i] && (r_cnt[i] != 2'd0);
`else
            w_push[i] = bus.src_valid[i] && bus.src_ready[i];
            w_pop[i]  = w_grant[i];
`endif
        end
    end

    // Control state: counts, pointers, round-robin, write ports
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_rr_ptr  <= '0;
            r_wp_en   <= '0;
            r_wp_idx  <= '0;
            r_wp_data <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                // Simultaneous push and pop leave the count unchanged.
                r_cnt[i] <= r_cnt[i] + {1'b0, w_push[i]} - {1'b0, w_pop[i]};
                if (w_push[i]) begin
                    r_wr_ptr[i] <= ~r_wr_ptr[i];
                end
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= ~r_rd_ptr[i];
                end
            end
            r_rr_ptr  <= w_rr_nxt;
            r_wp_en   <= w_slot_en;
            r_wp_idx  <= w_slot_idx;
            r_wp_data <= w_slot_data;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_push[i]) begin
                    r_mem_idx[i][r_wr_ptr[i]]  <= bus.src_index[i];
                    r_mem_data[i][r_wr_ptr[i]] <= bus.src_data[i];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
            bus.write_ports[k] = {r_wp_en[k], r_wp_idx[k], r_wp_data[k]};
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    localparam int W    = 64;
    localparam int NPR  = 128;
    localparam int NSRC = 4;
    localparam int NWP  = 2;
    localparam int IW   = $clog2(NPR);
`ifdef WB_ARBITER_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_arbiter_if #(.WORD_SIZE(W), .NUM_PHYS_REGS(NPR), .NUM_SRC(NSRC),
                    .NUM_WRITE_PORTS(NWP)) bus ();

    wb_arbiter #(.WORD_SIZE(W), .NUM_PHYS_REGS(NPR), .NUM_SRC(NSRC),
                 .NUM_WRITE_PORTS(NWP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
    } ent_t;

    ent_t sbq [NSRC][$];
    int   emitted [NSRC];
    int   total = 0;
    int   bad   = 0;
    bit   mon_on = 1'b0;

    // Top byte of every data word names its source.
    function automatic logic [W-1:0] mk(input int s, input int seq);
        mk = {8'(s), 56'(seq)};
    endfunction

    // Scoreboard: every emitted write pops the owning source's queue; idle
    // ports must read all-zero. Transfers are recorded here too.
    task automatic monitor();
        int   s;
        ent_t e;
        if (!mon_on) return;
        for (int k = 0; k < NWP; k++) begin
            total++;
            if (bus.write_ports[k].en === 1'b1) begin
                s = int'(bus.write_ports[k].data_in[W-1 -: 8]);
                if (s >= NSRC || sbq[s].size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected port%0d: got idx=%0d data=%h, want no write",
                             k, bus.write_ports[k].index_in, bus.write_ports[k].data_in);
                end else begin
                    e = sbq[s].pop_front();
                    emitted[s]++;
                    if (bus.write_ports[k].index_in !== e.idx || bus.write_ports[k].data_in !== e.data) begin
                        bad++;
                        $display("FAIL sb_order port%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                                 k, bus.write_ports[k].index_in, bus.write_ports[k].data_in, e.idx, e.data);
                    end
                end
            end else if (bus.write_ports[k].en !== 1'b0 || bus.write_ports[k].index_in !== '0
                         || bus.write_ports[k].data_in !== '0) begin
                bad++;
                $display("FAIL idle_port%0d: got en=%b idx=%h data=%h, want all zero",
                         k, bus.write_ports[k].en, bus.write_ports[k].index_in, bus.write_ports[k].data_in);
            end
        end
        if (rst) begin
            for (int i = 0; i < NSRC; i++) sbq[i].delete();
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (bus.src_valid[i] === 1'b1 && bus.src_ready[i] === 1'b1) begin
                    e.idx  = bus.src_index[i];
                    e.data = bus.src_data[i];
                    sbq[i].push_back(e);
                end
            end
        end
    endtask

    task automatic neg();
        @(negedge clk);
        monitor();
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.src_valid = '0;
        bus.src_index = '0;
        bus.src_data  = '0;
    endtask

    task automatic drive(input int s, input int idx, input logic [W-1:0] d);
        bus.src_valid[s] = 1'b1;
        bus.src_index[s] = IW'(idx);
        bus.src_data[s]  = d;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        neg();
        pos();
        rst = 1'b0;
    endtask

    task automatic check_port(input string nm, input int k, input logic en,
                              input int idx, input logic [W-1:0] d);
        total++;
        if (bus.write_ports[k].en !== en || bus.write_ports[k].index_in !== IW'(idx)
            || bus.write_ports[k].data_in !== d) begin
            bad++;
            $display("FAIL %s port%0d: got en=%b idx=%0d data=%h, want en=%b idx=%0d data=%h",
                     nm, k, bus.write_ports[k].en, bus.write_ports[k].index_in,
                     bus.write_ports[k].data_in, en, idx, d);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        pos();
        pos();
        mon_on = 1'b1;
        neg();
        check_port("reset", 0, 1'b0, 0, '0);
        check_port("reset", 1, 1'b0, 0, '0);
        total++;
        if (bus.src_ready !== 4'hF) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1111", bus.src_ready);
        end
        pos();
        rst = 1'b0;
    endtask

    task automatic test_single();
        drive(0, 5, 64'hDEAD);
        neg();
        total++;
        if (bus.src_ready !== 4'hF) begin
            bad++;
            $display("FAIL single_ready: got %b want 1111", bus.src_ready);
        end
        pos();
        idle_inputs();
`ifndef WB_ARBITER_BYPASS_EN
        neg();
        check_port("single_early", 0, 1'b0, 0, '0);
        pos();
`endif
        neg();
        check_port("single", 0, 1'b1, 5, 64'hDEAD);
        check_port("single", 1, 1'b0, 0, '0);
        pos();
        neg();
        check_port("single_after", 0, 1'b0, 0, '0);
        pos();
    endtask

    task automatic test_contention();
        reset_dut();
        for (int i = 0; i < NSRC; i++) drive(i, 10 + i, mk(i, 100 + i));
        neg();
        pos();
        idle_inputs();
        repeat (LAT - 1) begin neg(); pos(); end
        neg();
        check_port("cont_n", 0, 1'b1, 10, mk(0, 100));
        check_port("cont_n", 1, 1'b1, 11, mk(1, 101));
        pos();
        neg();
        check_port("cont_n1", 0, 1'b1, 12, mk(2, 102));
        check_port("cont_n1", 1, 1'b1, 13, mk(3, 103));
        pos();
        // rr_ptr back at 0: sources 0,1,3 compete, 0 and 1 must win first.
        drive(0, 20, mk(0, 20));
        drive(1, 21, mk(1, 21));
        drive(3, 23, mk(3, 23));
        neg();
        pos();
        idle_inputs();
        repeat (LAT - 1) begin neg(); pos(); end
        neg();
        check_port("rr_wrap", 0, 1'b1, 20, mk(0, 20));
        check_port("rr_wrap", 1, 1'b1, 21, mk(1, 21));
        pos();
        neg();
        check_port("rr_wrap_next", 0, 1'b1, 23, mk(3, 23));
        check_port("rr_wrap_next", 1, 1'b0, 0, '0);
        pos();
    endtask

    task automatic test_conflict();
        reset_dut();
        drive(0, 7, mk(0, 7));
        drive(1, 7, mk(1, 7));
        neg();
        pos();
        idle_inputs();
        repeat (LAT - 1) begin neg(); pos(); end
        neg();
        check_port("conflict", 0, 1'b1, 7, mk(0, 7));
        check_port("conflict", 1, 1'b0, 0, '0);
        pos();
        neg();
        check_port("conflict_next", 0, 1'b1, 7, mk(1, 7));
        check_port("conflict_next", 1, 1'b0, 0, '0);
        pos();
    endtask

    task automatic test_backpressure();
        int               seq [NSRC];
        logic [NSRC-1:0]  take;
        bit               saw_bp;
        bit               done;
        localparam int N = 6;
        reset_dut();
        saw_bp = 1'b0;
        for (int i = 0; i < NSRC; i++) begin seq[i] = 0; emitted[i] = 0; end
        for (int c = 0; c < 100; c++) begin
            done = 1'b1;
            for (int i = 0; i < NSRC; i++) begin
                if (seq[i] < N) begin
                    drive(i, i * 16 + seq[i], mk(i, seq[i]));
                    done = 1'b0;
                end else begin
                    bus.src_valid[i] = 1'b0;
                end
            end
            if (done) break;
            neg();
            if (bus.src_valid[2] === 1'b1 && bus.src_ready[2] === 1'b0) saw_bp = 1'b1;
            for (int i = 0; i < NSRC; i++) take[i] = bus.src_valid[i] && (bus.src_ready[i] === 1'b1);
            pos();
            for (int i = 0; i < NSRC; i++) if (take[i]) seq[i]++;
        end
        idle_inputs();
        for (int c = 0; c < 40; c++) begin
            neg();
            pos();
            if (sbq[0].size() == 0 && sbq[1].size() == 0 && sbq[2].size() == 0 && sbq[3].size() == 0) break;
        end
        total++;
        if (saw_bp !== 1'b1) begin
            bad++;
            $display("FAIL bp_ready2: got no src_ready[2]=0 cycle, want at least one");
        end
        for (int i = 0; i < NSRC; i++) begin
            total++;
            if (emitted[i] != N) begin
                bad++;
                $display("FAIL bp_count src%0d: got %0d writes want %0d", i, emitted[i], N);
            end
        end
    endtask

    task automatic test_reset_midflight();
        reset_dut();
        for (int i = 0; i < 3; i++) drive(i, 40 + i, mk(i, 40 + i));
        neg();
        pos();
        idle_inputs();
        rst = 1'b1;
        neg();
        pos();
        rst = 1'b0;
        neg();
        check_port("midrst", 0, 1'b0, 0, '0);
        check_port("midrst", 1, 1'b0, 0, '0);
        total++;
        if (bus.src_ready !== 4'hF) begin
            bad++;
            $display("FAIL midrst_ready: got %b want 1111", bus.src_ready);
        end
        pos();
        for (int c = 0; c < 6; c++) begin
            neg();
            total++;
            if (bus.write_ports[0].en !== 1'b0 || bus.write_ports[1].en !== 1'b0) begin
                bad++;
                $display("FAIL midrst_stale c%0d: got en=%b%b want 00", c,
                         bus.write_ports[1].en, bus.write_ports[0].en);
            end
            pos();
        end
    endtask

    task automatic test_streaming();
        reset_dut();
        for (int c = 0; c < 20 + LAT; c++) begin
            if (c < 20) drive(3, 60 + c, mk(3, c));
            else idle_inputs();
            neg();
            if (c < 20) begin
                total++;
                if (bus.src_ready[3] !== 1'b1) begin
                    bad++;
                    $display("FAIL stream_ready c%0d: got %b want 1", c, bus.src_ready[3]);
                end
            end
            if (c >= LAT) begin
                check_port("stream", 0, 1'b1, 60 + c - LAT, mk(3, c - LAT));
                check_port("stream", 1, 1'b0, 0, '0);
            end else begin
                check_port("stream_early", 0, 1'b0, 0, '0);
            end
            pos();
        end
        idle_inputs();
        neg();
        check_port("stream_end", 0, 1'b0, 0, '0);
        pos();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_conflict();
        test_backpressure();
        test_reset_midflight();
        test_streaming();
        for (int i = 0; i < NSRC; i++) begin
            total++;
            if (sbq[i].size() != 0) begin
                bad++;
                $display("FAIL leftover src%0d: got %0d pending want 0", i, sbq[i].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog expired");
    end
endmodule
